// File: rtl/i2c_frame_checker_if.sv
// ---------------------------------------------------------------------------
// i2c_frame_checker_if
// Bundles the frame-in / sample-out signals of i2c_frame_checker.
//   frame_data [23:0] {header, data, checksum}, stable while frame_done=1
//   frame_done        level from the read engine, high for several cycles
//   out_ready         sink accepts out_data when out_valid & out_ready
//   out_valid         out_data holds an unconsumed good sample
//   out_data   [7:0]  validated sensor byte
// Modports:
//   master : read engine + sample sink side (drives frames and out_ready)
//   slave  : the checker itself
// ---------------------------------------------------------------------------
interface i2c_frame_checker_if;
    logic [23:0] frame_data;
    logic        frame_done;
    logic        out_ready;
    logic        out_valid;
    logic [7:0]  out_data;

    modport master (
        output frame_data, frame_done, out_ready,
        input  out_valid, out_data
    );

    modport slave (
        input  frame_data, frame_done, out_ready,
        output out_valid, out_data
    );
endinterface

// File: rtl/i2c_frame_checker.sv
// ---------------------------------------------------------------------------
// i2c_frame_checker
// Consumes 3-byte read frames {header, data, checksum}, detects each new
// frame on the rising edge of frame_done, checks header and checksum, and
// offers good data bytes on a valid/ready output. Bad, dropped and missing
// frames are flagged and counted.
// Ports:
//   clk_1MHz  in   system clock
//   rst       in   synchronous reset, active-high
//   bus       slave modport of i2c_frame_checker_if (frame in, sample out)
//   hdr_err   out  1-cycle pulse, header mismatch
//   csum_err  out  1-cycle pulse, checksum mismatch with header OK
//   overrun   out  1-cycle pulse, good frame dropped while a sample is held
//   timeout   out  level, no frame for TIMEOUT_CYC cycles
//   ok_cnt    out  good frames loaded into HOLD, saturating
//   err_cnt   out  cycles with hdr/csum/overrun events, saturating
//   avg_data  out  mean of the last 4 good samples (I2C_FRAME_AVG_EN only)
// Optional feature macro: I2C_FRAME_AVG_EN (4-entry running average).
// ---------------------------------------------------------------------------
module i2c_frame_checker #(
    parameter logic [7:0] HEADER      = 8'hA5,
    parameter int         TIMEOUT_CYC = 2000,
    parameter int         CNT_W       = 16
) (
    input  logic             clk_1MHz,
    input  logic             rst,
    i2c_frame_checker_if.slave bus,
    output logic             hdr_err,
    output logic             csum_err,
    output logic             overrun,
    output logic             timeout,
    output logic [CNT_W-1:0] ok_cnt,
    output logic [CNT_W-1:0] err_cnt
`ifdef I2C_FRAME_AVG_EN
    ,
    output logic [7:0]       avg_data
`endif
);

    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // 8-bit checksum, carry discarded
    function automatic logic [7:0] csum8(input logic [7:0] h, input logic [7:0] d);
        return h + d;
    endfunction

    // Saturating counter increment
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    state_t           state_r;
    logic             done_q_r;
    logic [23:0]      frame_q_r;
    logic [TMR_W-1:0] timer_r;
    logic             chk_pend_r;   // frame captured in HOLD, checked next cycle

    logic             frame_evt_s;
    logic             hdr_bad_s;
    logic             csum_bad_s;
    logic             frame_good_s;
    logic             do_check_s;
    logic             err_evt_s;
    logic             accept_s;
    logic [TMR_W-1:0] timer_next_s;

    // Frame edge detect, check decode and timer next-state
    always_comb begin
        frame_evt_s  = bus.frame_done & ~done_q_r;
        hdr_bad_s    = (frame_q_r[23:16] != HEADER);
        csum_bad_s   = ~hdr_bad_s & (frame_q_r[7:0] != csum8(frame_q_r[23:16], frame_q_r[15:8]));
        frame_good_s = ~hdr_bad_s & ~csum_bad_s;
        do_check_s   = (state_r == CHECK) | chk_pend_r;
        // A good frame checked while holding is an overrun, hence an error
        err_evt_s    = do_check_s & (~frame_good_s | chk_pend_r);
        accept_s     = bus.out_valid & bus.out_ready;
        if (frame_evt_s) begin
            timer_next_s = {TMR_W{1'b0}};
        end else if (timer_r == TMR_MAX) begin
            timer_next_s = TMR_MAX;
        end else begin
            timer_next_s = timer_r + TMR_W'(1);
        end
    end

    // Main FSM, frame capture, timer, flags and counters
    always_ff @(posedge clk_1MHz) begin
        if (rst) begin
            state_r       <= IDLE;
            done_q_r      <= 1'b0;
            frame_q_r     <= 24'h000000;
            timer_r       <= {TMR_W{1'b0}};
            chk_pend_r    <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= 8'h00;
            hdr_err       <= 1'b0;
            csum_err      <= 1'b0;
            overrun       <= 1'b0;
            timeout       <= 1'b0;
            ok_cnt        <= {CNT_W{1'b0}};
            err_cnt       <= {CNT_W{1'b0}};
        end else begin
            done_q_r   <= bus.frame_done;
            timer_r    <= timer_next_s;
            timeout    <= (timer_next_s == TMR_MAX);
            hdr_err    <= do_check_s & hdr_bad_s;
            csum_err   <= do_check_s & csum_bad_s;
            overrun    <= chk_pend_r & frame_good_s;
            chk_pend_r <= 1'b0;
            if (err_evt_s) begin
                err_cnt <= sat_inc(err_cnt);
            end
            if (frame_evt_s) begin
                frame_q_r <= bus.frame_data;
            end
            case (state_r)
                IDLE: begin
                    if (frame_evt_s) begin
                        state_r <= CHECK;
                    end
                end
                CHECK: begin
                    if (frame_good_s) begin
                        bus.out_data  <= frame_q_r[15:8];
                        bus.out_valid <= 1'b1;
                        ok_cnt        <= sat_inc(ok_cnt);
                        state_r       <= HOLD;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                HOLD: begin
                    if (accept_s) begin
                        bus.out_valid <= 1'b0;
                        // A frame arriving with the accept is checked normally
                        state_r <= frame_evt_s ? CHECK : IDLE;
                    end else begin
                        chk_pend_r <= frame_evt_s;
                    end
                end
                default: begin
                    bus.out_valid <= 1'b0;
                    state_r       <= IDLE;
                end
            endcase
        end
    end

`ifdef I2C_FRAME_AVG_EN
    logic [7:0] hist_r [4];
    logic [9:0] avg_sum_s;

    // Sum of the new sample and the three most recent history entries
    always_comb begin
        avg_sum_s = 10'(frame_q_r[15:8]) + 10'(hist_r[0]) + 10'(hist_r[1]) + 10'(hist_r[2]);
    end

    // History shift and average, updated with each load into HOLD
    always_ff @(posedge clk_1MHz) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                hist_r[i] <= 8'h00;
            end
            avg_data <= 8'h00;
        end else if ((state_r == CHECK) && frame_good_s) begin
            hist_r[0] <= frame_q_r[15:8];
            hist_r[1] <= hist_r[0];
            hist_r[2] <= hist_r[1];
            hist_r[3] <= hist_r[2];
            avg_data  <= avg_sum_s[9:2];
        end
    end
`endif

endmodule

// File: tb/tb_i2c_frame_checker.sv
// ---------------------------------------------------------------------------
// tb_i2c_frame_checker
// Directed bench for i2c_frame_checker. Stimulus pushes expected output bytes
// and expected flag pulses into queues; a monitor on the falling edge pops and
// compares whenever a transfer or pulse occurs. Point checks cover reset,
// latency, counters, timeout and reset mid-frame.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_i2c_frame_checker;

    localparam logic [2:0] EV_HDR  = 3'b100;
    localparam logic [2:0] EV_CSUM = 3'b010;
    localparam logic [2:0] EV_OVR  = 3'b001;

    logic        clk_1MHz;
    logic        rst;
    logic        hdr_err, csum_err, overrun, timeout;
    logic [15:0] ok_cnt, err_cnt;
`ifdef I2C_FRAME_AVG_EN
    logic [7:0]  avg_data;
`endif

    int n_cmp;
    int n_bad;
    logic [7:0] exp_q[$];
    logic [2:0] evt_q[$];

    i2c_frame_checker_if bus ();

    i2c_frame_checker dut (
        .clk_1MHz (clk_1MHz),
        .rst      (rst),
        .bus      (bus),
        .hdr_err  (hdr_err),
        .csum_err (csum_err),
        .overrun  (overrun),
        .timeout  (timeout),
        .ok_cnt   (ok_cnt),
        .err_cnt  (err_cnt)
`ifdef I2C_FRAME_AVG_EN
        ,
        .avg_data (avg_data)
`endif
    );

    initial clk_1MHz = 1'b0;
    always #500 clk_1MHz = ~clk_1MHz;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one frame starting just after a rising edge, hold frame_done, then let it settle
    task automatic send(input logic [7:0] h, input logic [7:0] d, input logic [7:0] c, input int hold);
        @(posedge clk_1MHz); #1;
        bus.frame_data = {h, d, c};
        bus.frame_done = 1'b1;
        repeat (hold) @(posedge clk_1MHz);
        #1 bus.frame_done = 1'b0;
        repeat (3) @(posedge clk_1MHz);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk_1MHz); #1 rst = 1'b1;
        repeat (2) @(posedge clk_1MHz);
        #1 rst = 1'b0;
    endtask

    // Scoreboard monitor: pops expected bytes on transfers and expected pulses on flags
    always @(negedge clk_1MHz) begin
        if (!rst) begin
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL out_unexpected: got transfer of %0h, expected none", bus.out_data);
                end else begin
                    chk("out_data", bus.out_data, exp_q.pop_front());
                end
            end
            if ({hdr_err, csum_err, overrun} !== 3'b000) begin
                if (evt_q.size() == 0) begin
                    chk("evt_unexpected", {hdr_err, csum_err, overrun}, 3'b000);
                end else begin
                    chk("evt", {hdr_err, csum_err, overrun}, evt_q.pop_front());
                end
            end
        end
    end

    initial begin
        #10_000_000;
        $display("FAIL watchdog: got no finish, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit got_to;
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        bus.frame_data = 24'h000000;
        bus.frame_done = 1'b0;
        bus.out_ready  = 1'b0;
        repeat (3) @(posedge clk_1MHz);
        @(negedge clk_1MHz);
        chk("rst_valid",   bus.out_valid, 1'b0);
        chk("rst_data",    bus.out_data, 8'h00);
        chk("rst_flags",   {hdr_err, csum_err, overrun, timeout}, 4'h0);
        chk("rst_ok_cnt",  ok_cnt, 16'd0);
        chk("rst_err_cnt", err_cnt, 16'd0);
        #1 rst = 1'b0;

        // Good frame, latency of two cycles, one-cycle transfer
        bus.out_ready = 1'b1;
        exp_q.push_back(8'h3C);
        @(posedge clk_1MHz); #1;
        bus.frame_data = 24'hA53CE1;
        bus.frame_done = 1'b1;
        @(posedge clk_1MHz); @(negedge clk_1MHz);
        chk("lat_c1_valid", bus.out_valid, 1'b0);
        @(negedge clk_1MHz);
        chk("lat_c2_valid", bus.out_valid, 1'b1);
        chk("lat_c2_data",  bus.out_data, 8'h3C);
        @(negedge clk_1MHz);
        chk("lat_c3_valid", bus.out_valid, 1'b0);
        bus.frame_done = 1'b0;
        repeat (2) @(posedge clk_1MHz); #1;
        chk("t1_ok_cnt", ok_cnt, 16'd1);

        // Header error, then checksum error
        evt_q.push_back(EV_HDR);
        send(8'hA4, 8'h3C, 8'hE0, 3);
        evt_q.push_back(EV_CSUM);
        send(8'hA5, 8'h3C, 8'h00, 3);
        chk("t2_err_cnt", err_cnt, 16'd2);
        chk("t2_ok_cnt",  ok_cnt, 16'd1);

        // Overrun: second good frame dropped while the first is held
        do_reset();
        bus.out_ready = 1'b0;
        exp_q.push_back(8'h10);
        send(8'hA5, 8'h10, 8'hB5, 3);
        chk("t3_valid_hold", bus.out_valid, 1'b1);
        evt_q.push_back(EV_OVR);
        send(8'hA5, 8'h20, 8'hC5, 3);
        chk("t3_data_kept", bus.out_data, 8'h10);
        chk("t3_err_cnt",   err_cnt, 16'd1);
        chk("t3_ok_cnt",    ok_cnt, 16'd1);
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk_1MHz); #1;
        chk("t3_valid_drop", bus.out_valid, 1'b0);

        // Long frame_done level yields exactly one frame
        exp_q.push_back(8'h55);
        send(8'hA5, 8'h55, 8'hFA, 10);
        chk("t5_ok_cnt",  ok_cnt, 16'd2);
        chk("t5_err_cnt", err_cnt, 16'd1);

        // Timeout after 2000 idle cycles, cleared by the next frame
        repeat (1900) @(negedge clk_1MHz);
        chk("to_early", timeout, 1'b0);
        got_to = 1'b0;
        for (int i = 0; i < 300 && !got_to; i++) begin
            @(negedge clk_1MHz);
            if (timeout === 1'b1) got_to = 1'b1;
        end
        chk("to_reached", got_to, 1'b1);
        exp_q.push_back(8'h01);
        @(posedge clk_1MHz); #1;
        bus.frame_data = 24'hA501A6;
        bus.frame_done = 1'b1;
        @(negedge clk_1MHz);
        chk("to_before_evt", timeout, 1'b1);
        @(negedge clk_1MHz);
        chk("to_after_evt", timeout, 1'b0);
        #1 bus.frame_done = 1'b0;
        repeat (4) @(posedge clk_1MHz); #1;
        chk("t6_ok_cnt", ok_cnt, 16'd3);

        // Reset while in CHECK discards the frame
        @(posedge clk_1MHz); #1;
        bus.frame_data = 24'hA542E7;
        bus.frame_done = 1'b1;
        @(posedge clk_1MHz); #1;
        rst = 1'b1;
        bus.frame_done = 1'b0;
        @(posedge clk_1MHz); #1 rst = 1'b0;
        @(negedge clk_1MHz);
        chk("rchk_valid", bus.out_valid, 1'b0);
        chk("rchk_ok",    ok_cnt, 16'd0);
        chk("rchk_err",   err_cnt, 16'd0);
        repeat (4) @(negedge clk_1MHz);
        chk("rchk_no_load", bus.out_valid, 1'b0);

        // Reset while in HOLD clears the held sample
        bus.out_ready = 1'b0;
        send(8'hA5, 8'h77, 8'h1C, 3);
        chk("rhold_valid_before", bus.out_valid, 1'b1);
        @(posedge clk_1MHz); #1 rst = 1'b1;
        @(posedge clk_1MHz); #1 rst = 1'b0;
        @(negedge clk_1MHz);
        chk("rhold_valid", bus.out_valid, 1'b0);
        chk("rhold_data",  bus.out_data, 8'h00);
        chk("rhold_ok",    ok_cnt, 16'd0);
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk_1MHz); #1;

`ifdef I2C_FRAME_AVG_EN
        do_reset();
        exp_q.push_back(8'h04);
        send(8'hA5, 8'h04, 8'hA9, 3);
        chk("avg_1", avg_data, 8'h01);
        exp_q.push_back(8'h08);
        send(8'hA5, 8'h08, 8'hAD, 3);
        chk("avg_2", avg_data, 8'h03);
        exp_q.push_back(8'h0C);
        send(8'hA5, 8'h0C, 8'hB1, 3);
        chk("avg_3", avg_data, 8'h06);
        exp_q.push_back(8'h10);
        send(8'hA5, 8'h10, 8'hB5, 3);
        chk("avg_4", avg_data, 8'h0A);
`endif

        repeat (2) @(negedge clk_1MHz);
        chk("exp_q_left", exp_q.size(), 32'd0);
        chk("evt_q_left", evt_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
